nco_reset_sequencer: RTL and testbench

NCO_RESET_SEQUENCER -- requirements
Module: nco_reset_sequencer

---
 rtl/nco_reset_sequencer.sv | 121 ++++++++++++
 tb/tb_nco_reset_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_reset_sequencer.sv
// NCO reset sequencer: waits for a SYSREF edge, holds the RFDC NCO in reset for
// (wait + 1) SYSREF periods, and aborts with a sticky failure flag if SYSREF stops.
module nco_reset_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_nco_reset,
    input  logic       sysref,
    input  logic [7:0] sysref_wait_cycles,
    output logic       rfdc_nco_reset,
    output logic       nco_reset_done,
    output logic       nco_sync_failed,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for start; done/failed hold their last value
    // ARM   | waiting for the first SYSREF edge
    // HOLD  | NCO held in reset, counting down SYSREF periods
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_sysref_q;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_timeout_cnt;
    logic             w_sysref_edge;
    logic             w_active;
    logic             w_timeout;

    assign w_sysref_edge = sysref & ~r_sysref_q;
    assign w_active      = (r_state == S_ARM) || (r_state == S_HOLD);
    // An edge in the same cycle as the last allowed count wins over the timeout.
    assign w_timeout     = w_active && !w_sysref_edge && (r_timeout_cnt == TC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_nco_reset) w_next_state = S_ARM;
            end
            S_ARM: begin
                if (w_sysref_edge)  w_next_state = S_HOLD;
                else if (w_timeout) w_next_state = S_IDLE;
            end
            S_HOLD: begin
                if (w_sysref_edge) begin
                    if (r_wait_cnt == 8'd0) w_next_state = S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_ARM) || (r_state == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sysref_q      <= 1'b0;
            r_wait_cnt      <= 8'd0;
            r_timeout_cnt   <= '0;
            rfdc_nco_reset  <= 1'b0;
            nco_reset_done  <= 1'b0;
            nco_sync_failed <= 1'b0;
        end else begin
            r_sysref_q <= sysref;
            case (r_state)
                S_IDLE: begin
                    if (start_nco_reset) begin
                        r_wait_cnt      <= sysref_wait_cycles;
                        r_timeout_cnt   <= '0;
                        nco_reset_done  <= 1'b0;
                        nco_sync_failed <= 1'b0;
                    end
                end
                S_ARM, S_HOLD: begin
                    if (w_sysref_edge) begin
                        r_timeout_cnt <= '0;
                        if (r_state == S_ARM) begin
                            rfdc_nco_reset <= 1'b1;
                        end else if (r_wait_cnt == 8'd0) begin
                            rfdc_nco_reset <= 1'b0;
                            nco_reset_done <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 8'd1;
                        end
                    end else if (w_timeout) begin
                        rfdc_nco_reset  <= 1'b0;
                        nco_reset_done  <= 1'b0;
                        nco_sync_failed <= 1'b1;
                    end else begin
                        // Cannot wrap: reaching TC_LAST always takes the timeout branch.
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nco_reset_sequencer.sv
// Directed bench for nco_reset_sequencer: cycle-by-cycle expected waveforms for
// completion, wait counting, timeout, ignored mid-sequence inputs and async reset.
module tb_nco_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start_nco_reset;
    logic       sysref;
    logic [7:0] sysref_wait_cycles;
    logic       rfdc_nco_reset;
    logic       nco_reset_done;
    logic       nco_sync_failed;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    nco_reset_sequencer #(.TIMEOUT_CYCLES(64)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_nco_reset    (start_nco_reset),
        .sysref             (sysref),
        .sysref_wait_cycles (sysref_wait_cycles),
        .rfdc_nco_reset     (rfdc_nco_reset),
        .nco_reset_done     (nco_reset_done),
        .nco_sync_failed    (nco_sync_failed),
        .busy               (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SYSREF: period 16, width 2, first rise at cycle 'first', 'npulses' pulses.
    function automatic logic sref(input int c, input int first, input int npulses);
        if (c < first) return 1'b0;
        return ((c - first) % 16 < 2) && ((c - first) / 16 < npulses);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_nco_reset = 1'b0;
        sysref = 1'b1;
        sysref_wait_cycles = 8'd0;
        #23;
        checks++;
        if ({rfdc_nco_reset, nco_reset_done, nco_sync_failed, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {rfdc_nco_reset, nco_reset_done, nco_sync_failed, busy});
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({rfdc_nco_reset, nco_reset_done, nco_sync_failed, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_release_idle got=%b exp=0000",
                     {rfdc_nco_reset, nco_reset_done, nco_sync_failed, busy});
        end
        sysref = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait;
        logic e_rfdc, e_busy, e_done;
        sysref_wait_cycles = 8'd0;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) begin
                e_rfdc = (c >= 11) && (c <= 26);
                e_busy = (c <= 26);
                e_done = (c >= 27);
                checks++;
                if ({rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed} !== {e_rfdc, e_busy, e_done, 1'b0}) begin
                    failures++;
                    $display("FAIL zero_wait cyc=%0d rfdc/busy/done/failed got=%b exp=%b", c,
                             {rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed}, {e_rfdc, e_busy, e_done, 1'b0});
                end
            end
            start_nco_reset = (c == 0);
            sysref = sref(c, 10, 2);
            tick();
        end
    endtask

    task automatic test_wait3;
        logic e_rfdc, e_busy, e_done;
        sysref_wait_cycles = 8'd3;
        for (int c = 0; c <= 78; c++) begin
            if (c > 0) begin
                e_rfdc = (c >= 11) && (c <= 74);
                e_busy = (c <= 74);
                e_done = (c >= 75);
                checks++;
                if ({rfdc_nco_reset, busy, nco_reset_done} !== {e_rfdc, e_busy, e_done}) begin
                    failures++;
                    $display("FAIL wait3 cyc=%0d rfdc/busy/done got=%b exp=%b", c,
                             {rfdc_nco_reset, busy, nco_reset_done}, {e_rfdc, e_busy, e_done});
                end
            end
            start_nco_reset = (c == 0);
            sysref = sref(c, 10, 5);
            tick();
        end
    endtask

    task automatic test_start_edge;
        logic e_rfdc, e_done;
        sysref_wait_cycles = 8'd0;
        for (int c = 0; c <= 36; c++) begin
            if (c > 0) begin
                e_rfdc = (c >= 17) && (c <= 32);
                e_done = (c >= 33);
                checks++;
                if ({rfdc_nco_reset, nco_reset_done} !== {e_rfdc, e_done}) begin
                    failures++;
                    $display("FAIL start_edge cyc=%0d rfdc/done got=%b exp=%b", c,
                             {rfdc_nco_reset, nco_reset_done}, {e_rfdc, e_done});
                end
            end
            start_nco_reset = (c == 0);
            sysref = sref(c, 0, 3);
            tick();
        end
    endtask

    task automatic test_no_sysref;
        logic e_busy, e_failed;
        sysref_wait_cycles = 8'd0;
        for (int c = 0; c <= 70; c++) begin
            if (c > 0) begin
                e_busy   = (c <= 64);
                e_failed = (c >= 65);
                checks++;
                if ({rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed} !== {1'b0, e_busy, 1'b0, e_failed}) begin
                    failures++;
                    $display("FAIL no_sysref cyc=%0d rfdc/busy/done/failed got=%b exp=%b", c,
                             {rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed}, {1'b0, e_busy, 1'b0, e_failed});
                end
            end
            start_nco_reset = (c == 0);
            sysref = 1'b0;
            tick();
        end
    endtask

    task automatic test_recovery;
        logic e_rfdc, e_done;
        checks++;
        if (nco_sync_failed !== 1'b1) begin
            failures++;
            $display("FAIL recovery_precond failed got=%b exp=1", nco_sync_failed);
        end
        sysref_wait_cycles = 8'd0;
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) begin
                e_rfdc = (c >= 11) && (c <= 26);
                e_done = (c >= 27);
                checks++;
                if ({rfdc_nco_reset, nco_reset_done, nco_sync_failed} !== {e_rfdc, e_done, 1'b0}) begin
                    failures++;
                    $display("FAIL recovery cyc=%0d rfdc/done/failed got=%b exp=%b", c,
                             {rfdc_nco_reset, nco_reset_done, nco_sync_failed}, {e_rfdc, e_done, 1'b0});
                end
            end
            start_nco_reset = (c == 0);
            sysref = sref(c, 10, 2);
            tick();
        end
    endtask

    task automatic test_mid_changes;
        logic e_rfdc, e_busy, e_done;
        for (int c = 0; c <= 62; c++) begin
            if (c > 0) begin
                e_rfdc = (c >= 11) && (c <= 58);
                e_busy = (c <= 58);
                e_done = (c >= 59);
                checks++;
                if ({rfdc_nco_reset, busy, nco_reset_done} !== {e_rfdc, e_busy, e_done}) begin
                    failures++;
                    $display("FAIL mid_changes cyc=%0d rfdc/busy/done got=%b exp=%b", c,
                             {rfdc_nco_reset, busy, nco_reset_done}, {e_rfdc, e_busy, e_done});
                end
            end
            start_nco_reset = (c == 0) || (c == 20);
            sysref_wait_cycles = (c < 20) ? 8'd2 : 8'd9;
            sysref = sref(c, 10, 6);
            tick();
        end
    endtask

    task automatic test_async_reset;
        logic e_rfdc, e_done;
        sysref_wait_cycles = 8'd1;
        for (int c = 0; c <= 14; c++) begin
            start_nco_reset = (c == 0);
            sysref = sref(c, 10, 1);
            tick();
        end
        checks++;
        if ({rfdc_nco_reset, busy} !== 2'b11) begin
            failures++;
            $display("FAIL async_precond rfdc/busy got=%b exp=11", {rfdc_nco_reset, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0000",
                     {rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed});
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if ({rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed} !== 4'b0000) begin
            failures++;
            $display("FAIL async_after_release got=%b exp=0000",
                     {rfdc_nco_reset, busy, nco_reset_done, nco_sync_failed});
        end
        sysref_wait_cycles = 8'd0;
        for (int c = 0; c <= 28; c++) begin
            if (c > 0) begin
                e_rfdc = (c >= 11) && (c <= 26);
                e_done = (c >= 27);
                checks++;
                if ({rfdc_nco_reset, nco_reset_done} !== {e_rfdc, e_done}) begin
                    failures++;
                    $display("FAIL async_rerun cyc=%0d rfdc/done got=%b exp=%b", c,
                             {rfdc_nco_reset, nco_reset_done}, {e_rfdc, e_done});
                end
            end
            start_nco_reset = (c == 0);
            sysref = sref(c, 10, 2);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait3();
        test_start_edge();
        test_no_sysref();
        test_recovery();
        test_mid_changes();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
